p_encoder_scan: RTL and testbench

- Sequential, parametrised successor to the single-shot priority encoder.
- Accepts a BW-bit vector over a valid/ready handshake and emits the index of every set bit, one per output beat, in a fixed priority order.
- Flags the last beat. An all-zero vector produces a single zero-flagged beat.
- Sits between the activation/weight bit-slicing logic and the approximate multiplier datapath, where one-hot or sparse bit positions are consumed serially.

---
 rtl/p_encoder_scan_if.sv | 37 +++
 rtl/p_encoder_scan.sv | 122 ++++++++++++
 tb/tb_p_encoder_scan.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/p_encoder_scan_if.sv
// Handshake bundle for p_encoder_scan: vector input channel, index output channel, busy.
// The optional out_cnt signal exists only when P_ENC_COUNT_EN is defined.
interface p_encoder_scan_if #(
  parameter int BW = 8
);
  localparam int IW = $clog2(BW);
  localparam int CW = $clog2(BW + 1);

  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_a;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_zero;
  logic          busy;
`ifdef P_ENC_COUNT_EN
  logic [CW-1:0] out_cnt;
`endif

  modport master (
    output in_valid, in_a, out_ready,
`ifdef P_ENC_COUNT_EN
    input  out_cnt,
`endif
    input  in_ready, out_valid, out_idx, out_last, out_zero, busy
  );

  modport slave (
    input  in_valid, in_a, out_ready,
`ifdef P_ENC_COUNT_EN
    output out_cnt,
`endif
    output in_ready, out_valid, out_idx, out_last, out_zero, busy
  );
endinterface

// File: rtl/p_encoder_scan.sv
// Sequential priority encoder: emits the index of every set bit of an accepted vector,
// one beat per cycle. Optional popcount output under macro P_ENC_COUNT_EN.
//
// state | meaning
// IDLE  | no vector held, in_ready=1, out_valid=0
// SCAN  | vector held in pending_q, one beat presented per cycle
module p_encoder_scan #(
  parameter int BW        = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  p_encoder_scan_if.slave bus
);
  localparam int IW = $clog2(BW);
  localparam int CW = $clog2(BW + 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q;
  logic [BW-1:0] pending_q;
  logic          zero_q;
  logic          valid_q;
  logic          busy_q;

  logic [IW-1:0] pri_idx;
  logic [BW-1:0] clr_mask;
  logic          single;
  logic          last;
  logic          xfer;
  logic          accept;
  logic          ready;

  always_comb begin
    pri_idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < BW; i++)
        if (pending_q[i]) pri_idx = IW'(i);
    end else begin
      for (int i = BW - 1; i >= 0; i--)
        if (pending_q[i]) pri_idx = IW'(i);
    end
    clr_mask = BW'(1) << pri_idx;
  end

  // at most one bit left means the current beat is the final one
  assign single = ((pending_q & (pending_q - BW'(1))) == '0);
  assign last   = valid_q & (zero_q | single);
  assign xfer   = valid_q & bus.out_ready;
  assign ready  = (state_q == IDLE) | (xfer & last);
  assign accept = bus.in_valid & ready;

`ifdef P_ENC_COUNT_EN
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_in;

  always_comb begin
    cnt_in = '0;
    for (int i = 0; i < BW; i++) cnt_in = cnt_in + CW'(bus.in_a[i]);
  end

  assign bus.out_cnt = cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef P_ENC_COUNT_EN
      cnt_q     <= '0;
`endif
    end else if (accept) begin
      // covers both the IDLE load and the back-to-back reload on a final beat
      state_q   <= SCAN;
      pending_q <= bus.in_a;
      zero_q    <= (bus.in_a == '0);
      valid_q   <= 1'b1;
      busy_q    <= 1'b1;
`ifdef P_ENC_COUNT_EN
      cnt_q     <= cnt_in;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        SCAN: begin
          if (xfer) begin
            if (last) begin
              state_q   <= IDLE;
              pending_q <= '0;
              zero_q    <= 1'b0;
              valid_q   <= 1'b0;
              busy_q    <= 1'b0;
`ifdef P_ENC_COUNT_EN
              cnt_q     <= '0;
`endif
            end else begin
              pending_q <= pending_q & ~clr_mask;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = pri_idx;
  assign bus.out_last  = last;
  assign bus.out_zero  = zero_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_p_encoder_scan.sv
// Directed bench for p_encoder_scan: table of vectors for both scan orders plus
// hand-written reset, backpressure, back-to-back and mid-scan reset sequences.
module tb_p_encoder_scan;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p_encoder_scan_if #(.BW(BW)) b0 ();
  p_encoder_scan_if #(.BW(BW)) b1 ();

  p_encoder_scan #(.BW(BW), .MSB_FIRST(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  p_encoder_scan #(.BW(BW), .MSB_FIRST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int n_cmp = 0;
  int n_err = 0;
  bit sel = 1'b0;

  logic       s_valid, s_last, s_zero, s_busy, s_ready;
  logic [2:0] s_idx;
  int         s_cnt;

  always_comb begin
    s_valid = sel ? b1.out_valid : b0.out_valid;
    s_last  = sel ? b1.out_last  : b0.out_last;
    s_zero  = sel ? b1.out_zero  : b0.out_zero;
    s_busy  = sel ? b1.busy      : b0.busy;
    s_ready = sel ? b1.in_ready  : b0.in_ready;
    s_idx   = sel ? b1.out_idx   : b0.out_idx;
    s_cnt   = 0;
`ifdef P_ENC_COUNT_EN
    s_cnt   = sel ? int'(b1.out_cnt) : int'(b0.out_cnt);
`endif
  end

  typedef struct {
    logic [7:0] vec;
    bit         msb;
    int         n;
    bit         zero;
    int         cnt;
    int         idx[8];
  } rec_t;

  rec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input bit v, input logic [7:0] a);
    if (sel) begin
      b1.in_valid = v; b1.in_a = a;
    end else begin
      b0.in_valid = v; b0.in_a = a;
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input bit lst, input bit zro);
    chk({tag, " out_valid"}, int'(s_valid), 1);
    chk({tag, " out_idx"}, int'(s_idx), idx);
    chk({tag, " out_last"}, int'(s_last), int'(lst));
    chk({tag, " out_zero"}, int'(s_zero), int'(zro));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " out_valid"}, int'(s_valid), 0);
    chk({tag, " busy"}, int'(s_busy), 0);
    chk({tag, " in_ready"}, int'(s_ready), 1);
  endtask

  initial begin
    b0.in_valid = 1'b0; b0.in_a = '0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_a = '0; b1.out_ready = 1'b1;

    tbl[0] = '{vec:8'h24, msb:1'b0, n:2, zero:1'b0, cnt:2, idx:'{2,5,0,0,0,0,0,0}};
    tbl[1] = '{vec:8'h00, msb:1'b0, n:1, zero:1'b1, cnt:0, idx:'{0,0,0,0,0,0,0,0}};
    tbl[2] = '{vec:8'hFF, msb:1'b1, n:8, zero:1'b0, cnt:8, idx:'{7,6,5,4,3,2,1,0}};
    tbl[3] = '{vec:8'hA5, msb:1'b0, n:4, zero:1'b0, cnt:4, idx:'{0,2,5,7,0,0,0,0}};
    tbl[4] = '{vec:8'hA5, msb:1'b1, n:4, zero:1'b0, cnt:4, idx:'{7,5,2,0,0,0,0,0}};
    tbl[5] = '{vec:8'h80, msb:1'b0, n:1, zero:1'b0, cnt:1, idx:'{7,0,0,0,0,0,0,0}};
    tbl[6] = '{vec:8'h01, msb:1'b1, n:1, zero:1'b0, cnt:1, idx:'{0,0,0,0,0,0,0,0}};
    tbl[7] = '{vec:8'hFF, msb:1'b0, n:8, zero:1'b0, cnt:8, idx:'{0,1,2,3,4,5,6,7}};

    // reset held for two cycles, all outputs low
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst out_valid", int'(b0.out_valid), 0);
      chk("rst out_idx", int'(b0.out_idx), 0);
      chk("rst out_last", int'(b0.out_last), 0);
      chk("rst out_zero", int'(b0.out_zero), 0);
      chk("rst busy", int'(b0.busy), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) begin
      sel = tbl[t].msb;
      drv(1'b1, tbl[t].vec);
      @(posedge clk); #1;
      drv(1'b0, 8'hC3);
      for (int k = 0; k < tbl[t].n; k++) begin
        @(negedge clk);
        chk_beat($sformatf("vec%0d beat%0d", t, k), tbl[t].idx[k], k == tbl[t].n - 1, tbl[t].zero);
        chk($sformatf("vec%0d beat%0d busy", t, k), int'(s_busy), 1);
`ifdef P_ENC_COUNT_EN
        chk($sformatf("vec%0d beat%0d out_cnt", t, k), s_cnt, tbl[t].cnt);
`endif
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk_idle($sformatf("vec%0d done", t));
      @(posedge clk); #1;
    end
    sel = 1'b0;

    // backpressure: first beat held four cycles, new offers ignored during the stall
    drv(1'b1, 8'h81);
    @(posedge clk); #1;
    drv(1'b0, 8'h00);
    b0.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k == 1) drv(1'b1, 8'hFF);
      @(negedge clk);
      chk_beat($sformatf("stall%0d", k), 0, 1'b0, 1'b0);
      chk($sformatf("stall%0d in_ready", k), int'(b0.in_ready), 0);
    end
    drv(1'b0, 8'h00);
    b0.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_beat("stall end", 7, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle("stall done");
    @(posedge clk); #1;

    // back-to-back: second vector loads on the final beat of the first
    drv(1'b1, 8'h10);
    @(posedge clk); #1;
    drv(1'b1, 8'h03);
    @(negedge clk);
    chk_beat("b2b v0", 4, 1'b1, 1'b0);
    chk("b2b in_ready", int'(b0.in_ready), 1);
    @(posedge clk); #1;
    drv(1'b0, 8'h00);
    @(negedge clk);
    chk_beat("b2b v1 b0", 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_beat("b2b v1 b1", 1, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle("b2b done");
    @(posedge clk); #1;

    // mid-scan reset discards the rest of 8'hF0
    drv(1'b1, 8'hF0);
    @(posedge clk); #1;
    drv(1'b0, 8'h00);
    @(negedge clk);
    chk_beat("mid b0", 4, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_idle($sformatf("mid post%0d", k));
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
